fsm_seq_event_logger: RTL and testbench

//  Downstream stage of the 101/110 Mealy sequence detector. Samples the detector's 2-bit

---
 rtl/fsm_seq_event_logger.sv | 103 ++++++++++
 tb/tb_fsm_seq_event_logger.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_seq_event_logger.sv
// Event logger behind the 101/110 sequence detector: saturating hit counters plus a
// first-word-fall-through FIFO of {code, timestamp} records drained over valid/ready.
module fsm_seq_event_logger #(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned TS_W  = 16,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic [1:0]               i_y,
   input  logic                     i_clr,
   input  logic                     i_evt_ready,
   output logic                     o_evt_valid,
   output logic [1:0]               o_evt_code,
   output logic [TS_W-1:0]          o_evt_time,
   output logic [CNT_W-1:0]         o_cnt_101,
   output logic [CNT_W-1:0]         o_cnt_110,
   output logic [$clog2(DEPTH):0]   o_level,
   output logic                     o_overflow
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;

   typedef struct packed {
      logic [1:0]      code;
      logic [TS_W-1:0] ts;
   } evt_rec_t;

   evt_rec_t         mem [DEPTH];
   evt_rec_t         head;
   logic [TS_W-1:0]  ts_q;
   logic [CNT_W-1:0] cnt_101_q;
   logic [CNT_W-1:0] cnt_110_q;
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [LVL_W-1:0] level_q;
   logic             overflow_q;

   logic evt_c;
   logic hit_101_c;
   logic hit_110_c;
   logic full_c;
   logic pop_c;
   logic push_c;
   logic drop_c;

   // A pop on a full FIFO frees the slot for a simultaneous push
   always_comb begin
      evt_c     = i_y[1];
      hit_101_c = (i_y == 2'b10);
      hit_110_c = (i_y == 2'b11);
      full_c    = (level_q == LVL_W'(DEPTH));
      pop_c     = (level_q != '0) && i_evt_ready;
      push_c    = evt_c && (!full_c || pop_c);
      drop_c    = evt_c && full_c && !pop_c;
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         ts_q       <= '0;
         cnt_101_q  <= '0;
         cnt_110_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else if (i_clr) begin
         ts_q       <= '0;
         cnt_101_q  <= '0;
         cnt_110_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         ts_q <= ts_q + TS_W'(1);
         if (hit_101_c && (cnt_101_q != '1)) cnt_101_q <= cnt_101_q + CNT_W'(1);
         if (hit_110_c && (cnt_110_q != '1)) cnt_110_q <= cnt_110_q + CNT_W'(1);
         if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         level_q <= level_q + LVL_W'(push_c) - LVL_W'(pop_c);
         if (drop_c) overflow_q <= 1'b1;
      end
   end

   // Record storage needs no reset: occupancy alone decides what is visible
   always_ff @(posedge i_clk) begin
      if (!i_reset && !i_clr && push_c) mem[wr_ptr_q] <= '{code: i_y, ts: ts_q};
   end

   always_comb begin
      head        = mem[rd_ptr_q];
      o_evt_valid = (level_q != '0);
      o_evt_code  = o_evt_valid ? head.code : 2'b00;
      o_evt_time  = o_evt_valid ? head.ts   : '0;
      o_cnt_101   = cnt_101_q;
      o_cnt_110   = cnt_110_q;
      o_level     = level_q;
      o_overflow  = overflow_q;
   end

endmodule

// File: tb/tb_fsm_seq_event_logger.sv
// Self-checking bench for fsm_seq_event_logger: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_fsm_seq_event_logger;

   localparam int unsigned CNT_W = 4;
   localparam int unsigned TS_W  = 8;
   localparam int unsigned DEPTH = 8;
   localparam int          CMAX  = (1 << CNT_W) - 1;
   localparam int          TMOD  = 1 << TS_W;

   logic                   clk = 1'b0;
   logic                   i_reset;
   logic [1:0]             i_y;
   logic                   i_clr;
   logic                   i_evt_ready;
   logic                   o_evt_valid;
   logic [1:0]             o_evt_code;
   logic [TS_W-1:0]        o_evt_time;
   logic [CNT_W-1:0]       o_cnt_101;
   logic [CNT_W-1:0]       o_cnt_110;
   logic [$clog2(DEPTH):0] o_level;
   logic                   o_overflow;

   fsm_seq_event_logger #(.CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
      .i_clk       (clk),
      .i_reset     (i_reset),
      .i_y         (i_y),
      .i_clr       (i_clr),
      .i_evt_ready (i_evt_ready),
      .o_evt_valid (o_evt_valid),
      .o_evt_code  (o_evt_code),
      .o_evt_time  (o_evt_time),
      .o_cnt_101   (o_cnt_101),
      .o_cnt_110   (o_cnt_110),
      .o_level     (o_level),
      .o_overflow  (o_overflow)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: logged records as a queue, counters and timestamp as integers
   typedef struct {
      int code;
      int ts;
   } rec_t;
   rec_t m_q[$];
   int   m_ts, m_c101, m_c110;
   bit   m_ovf;

   typedef struct {
      logic [1:0] y;
      logic       clr;
      logic       rdy;
      logic       v;
      int         lvl;
      int         a;
      int         b;
      logic       ov;
      int         code;
      int         tm;
   } vec_t;
   vec_t tbl[12];

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_q.delete();
      m_ts = 0; m_c101 = 0; m_c110 = 0; m_ovf = 0;
   endtask

   task automatic model_edge(input logic [1:0] y, input logic clr, input logic rdy);
      rec_t r;
      if (clr) begin
         model_clear();
         return;
      end
      if (y == 2'b10 && m_c101 < CMAX) m_c101++;
      if (y == 2'b11 && m_c110 < CMAX) m_c110++;
      if (rdy && m_q.size() > 0) void'(m_q.pop_front());
      if (y[1]) begin
         if (m_q.size() < DEPTH) begin
            r.code = int'(y);
            r.ts   = m_ts;
            m_q.push_back(r);
         end else begin
            m_ovf = 1;
         end
      end
      m_ts = (m_ts + 1) % TMOD;
   endtask

   task automatic drive(input logic [1:0] y, input logic clr, input logic rdy);
      i_y = y; i_clr = clr; i_evt_ready = rdy;
      @(posedge clk);
      model_edge(y, clr, rdy);
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".valid"}, int'(o_evt_valid), int'(m_q.size() != 0));
      chk({tag, ".level"}, int'(o_level), m_q.size());
      chk({tag, ".cnt101"}, int'(o_cnt_101), m_c101);
      chk({tag, ".cnt110"}, int'(o_cnt_110), m_c110);
      chk({tag, ".ovf"}, int'(o_overflow), int'(m_ovf));
      if (m_q.size() != 0) begin
         chk({tag, ".code"}, int'(o_evt_code), m_q[0].code);
         chk({tag, ".time"}, int'(o_evt_time), m_q[0].ts);
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".valid"}, int'(o_evt_valid), 0);
      chk({tag, ".level"}, int'(o_level), 0);
      chk({tag, ".code"}, int'(o_evt_code), 0);
      chk({tag, ".time"}, int'(o_evt_time), 0);
      chk({tag, ".cnt101"}, int'(o_cnt_101), 0);
      chk({tag, ".cnt110"}, int'(o_cnt_110), 0);
      chk({tag, ".ovf"}, int'(o_overflow), 0);
   endtask

   task automatic do_reset();
      i_reset = 1'b1; i_y = 2'b00; i_clr = 1'b0; i_evt_ready = 1'b0;
      model_clear();
      @(negedge clk);
      @(negedge clk);
      i_reset = 1'b0;
      check_zero("reset");
   endtask

   initial begin
      // Directed vectors starting at ts=5 after reset
      tbl[0]  = '{2'b10, 1'b0, 1'b0, 1'b1, 1, 1, 0, 1'b0, 2, 5};
      tbl[1]  = '{2'b00, 1'b0, 1'b0, 1'b1, 1, 1, 0, 1'b0, 2, 5};
      tbl[2]  = '{2'b00, 1'b0, 1'b0, 1'b1, 1, 1, 0, 1'b0, 2, 5};
      tbl[3]  = '{2'b00, 1'b0, 1'b0, 1'b1, 1, 1, 0, 1'b0, 2, 5};
      tbl[4]  = '{2'b11, 1'b0, 1'b0, 1'b1, 2, 1, 1, 1'b0, 2, 5};
      tbl[5]  = '{2'b00, 1'b0, 1'b1, 1'b1, 1, 1, 1, 1'b0, 3, 9};
      tbl[6]  = '{2'b00, 1'b0, 1'b1, 1'b0, 0, 1, 1, 1'b0, 0, 0};
      tbl[7]  = '{2'b01, 1'b0, 1'b1, 1'b0, 0, 1, 1, 1'b0, 0, 0};
      tbl[8]  = '{2'b10, 1'b0, 1'b1, 1'b1, 1, 2, 1, 1'b0, 2, 13};
      tbl[9]  = '{2'b11, 1'b0, 1'b1, 1'b1, 1, 2, 2, 1'b0, 3, 14};
      tbl[10] = '{2'b00, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0};
      tbl[11] = '{2'b10, 1'b0, 1'b0, 1'b1, 1, 1, 0, 1'b0, 2, 0};

      // Idle for 20 cycles, then an event must carry ts=20
      do_reset();
      repeat (20) drive(2'b00, 1'b0, 1'b0);
      check_model("idle");
      drive(2'b10, 1'b0, 1'b0);
      chk("idle.ts20", int'(o_evt_time), 20);
      check_model("idle.evt");

      // Table-driven directed sequence
      do_reset();
      repeat (5) drive(2'b00, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].y, tbl[i].clr, tbl[i].rdy);
         chk($sformatf("tbl%0d.valid", i), int'(o_evt_valid), int'(tbl[i].v));
         chk($sformatf("tbl%0d.level", i), int'(o_level), tbl[i].lvl);
         chk($sformatf("tbl%0d.cnt101", i), int'(o_cnt_101), tbl[i].a);
         chk($sformatf("tbl%0d.cnt110", i), int'(o_cnt_110), tbl[i].b);
         chk($sformatf("tbl%0d.ovf", i), int'(o_overflow), int'(tbl[i].ov));
         if (tbl[i].v) begin
            chk($sformatf("tbl%0d.code", i), int'(o_evt_code), tbl[i].code);
            chk($sformatf("tbl%0d.time", i), int'(o_evt_time), tbl[i].tm);
         end
      end

      // Overflow: 10 events into an undrained FIFO, then in-order drain of the first 8
      do_reset();
      for (int i = 0; i < 10; i++) begin
         drive((i % 2 == 0) ? 2'b10 : 2'b11, 1'b0, 1'b0);
         if (i == 7) begin
            chk("ovf.lvl8", int'(o_level), 8);
            chk("ovf.not_yet", int'(o_overflow), 0);
         end
         if (i == 8) chk("ovf.set", int'(o_overflow), 1);
      end
      chk("ovf.total", int'(o_cnt_101) + int'(o_cnt_110), 10);
      for (int i = 0; i < 8; i++) begin
         chk("ovf.drain_code", int'(o_evt_code), (i % 2 == 0) ? 2 : 3);
         chk("ovf.drain_time", int'(o_evt_time), i);
         drive(2'b00, 1'b0, 1'b1);
      end
      chk("ovf.empty", int'(o_evt_valid), 0);
      chk("ovf.sticky", int'(o_overflow), 1);

      // Full FIFO with simultaneous pop and push: new record becomes the tail
      do_reset();
      repeat (8) drive(2'b10, 1'b0, 1'b0);
      drive(2'b11, 1'b0, 1'b1);
      chk("fullpp.level", int'(o_level), 8);
      chk("fullpp.ovf", int'(o_overflow), 0);
      for (int i = 1; i <= 8; i++) begin
         chk("fullpp.time", int'(o_evt_time), i);
         chk("fullpp.code", int'(o_evt_code), (i == 8) ? 3 : 2);
         drive(2'b00, 1'b0, 1'b1);
      end
      check_model("fullpp.end");

      // Saturation of the 4-bit counter
      do_reset();
      repeat (20) drive(2'b11, 1'b0, 1'b1);
      chk("sat.cnt110", int'(o_cnt_110), 15);
      chk("sat.cnt101", int'(o_cnt_101), 0);
      check_model("sat");

      // Clear beats a same-edge event and pop, also clearing overflow
      do_reset();
      repeat (9) drive(2'b10, 1'b0, 1'b0);
      repeat (5) drive(2'b00, 1'b0, 1'b1);
      chk("clr.pre_level", int'(o_level), 3);
      chk("clr.pre_ovf", int'(o_overflow), 1);
      drive(2'b10, 1'b1, 1'b1);
      check_zero("clr");
      drive(2'b11, 1'b0, 1'b0);
      chk("clr.ts_restart", int'(o_evt_time), 0);
      check_model("clr.after");

      // Asynchronous reset in the middle of a drain
      repeat (4) drive(2'b10, 1'b0, 1'b0);
      drive(2'b00, 1'b0, 1'b1);
      #1 i_reset = 1'b1;
      model_clear();
      #1 check_zero("areset");
      @(negedge clk);
      i_reset = 1'b0;
      drive(2'b00, 1'b0, 1'b0);
      check_model("areset.after");

      // Randomized traffic with varying consumer back-pressure
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         int rdy_pct;
         case ((i / 200) % 3)
            0:       rdy_pct = 10;
            1:       rdy_pct = 50;
            default: rdy_pct = 90;
         endcase
         drive(2'($urandom_range(0, 3)), ($urandom_range(0, 99) == 0),
               ($urandom_range(0, 99) < rdy_pct));
         check_model("rand");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
